// File: rtl/apb3_ms_slave_mem.sv
// APB3 completer backed by a word-addressed memory array.
// Supports programmable wait states, byte strobes, range/alignment errors and abort detection.
module apb3_ms_slave_mem #(
    parameter int unsigned              DATA_WIDTH = 32,
    parameter int unsigned              ADDR_WIDTH = 32,
    parameter int unsigned              STRB_WIDTH = DATA_WIDTH / 8,
    parameter int unsigned              DEPTH      = 16,
    parameter logic [ADDR_WIDTH-1:0]    BASE_ADDR  = '0
) (
    input  logic                    PCLK,
    input  logic                    PRESETn,
    input  logic                    PSELx,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [ADDR_WIDTH-1:0]   PADDR,
    input  logic [DATA_WIDTH-1:0]   PWDATA,
    input  logic [STRB_WIDTH-1:0]   PSTRB,
    input  logic [3:0]              wait_cfg,
    output logic                    PREADY,
    output logic [DATA_WIDTH-1:0]   PRDATA,
    output logic                    PSLVERR,
    output logic                    abort_o
);

    localparam int unsigned             IDX_W      = $clog2(DEPTH);
    localparam int unsigned             LSB        = $clog2(STRB_WIDTH);
    localparam logic [ADDR_WIDTH-1:0]   SPAN       = ADDR_WIDTH'(DEPTH * STRB_WIDTH);
    localparam logic [ADDR_WIDTH-1:0]   ALIGN_MASK = ADDR_WIDTH'(STRB_WIDTH - 1);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    state_t                 state_q;
    logic [3:0]             cnt_q;
    logic [IDX_W-1:0]       idx_q;
    logic                   write_q;
    logic [DATA_WIDTH-1:0]  wdata_q;
    logic [STRB_WIDTH-1:0]  strb_q;
    logic                   err_q;
    logic                   pready_q;
    logic [DATA_WIDTH-1:0]  prdata_q;
    logic                   pslverr_q;
    logic                   abort_q;
    logic [DATA_WIDTH-1:0]  mem_q [DEPTH];

    logic [ADDR_WIDTH-1:0]  off_c;
    logic [IDX_W-1:0]       idx_c;
    logic                   err_c;
    logic                   setup_c;
    logic                   active_c;

    // Address decode of the live bus address (used only on the setup edge)
    assign off_c    = PADDR - BASE_ADDR;
    assign idx_c    = IDX_W'(off_c >> LSB);
    assign err_c    = (off_c >= SPAN) || ((PADDR & ALIGN_MASK) != '0);
    assign setup_c  = PSELx && !PENABLE;
    assign active_c = PSELx && PENABLE;

    // Transfer sequencing, wait-state counting, response generation and memory update
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            idx_q     <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            strb_q    <= '0;
            err_q     <= 1'b0;
            pready_q  <= 1'b0;
            prdata_q  <= '0;
            pslverr_q <= 1'b0;
            abort_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            abort_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    pready_q  <= 1'b0;
                    pslverr_q <= 1'b0;
                    prdata_q  <= '0;
                end
                ST_ACCESS: begin
                    if (active_c) begin
                        if (!pready_q) begin
                            // Wait states: respond on the edge where the count reaches zero
                            cnt_q <= cnt_q - 4'd1;
                            if (cnt_q == 4'd1) begin
                                pready_q  <= 1'b1;
                                pslverr_q <= err_q;
                                prdata_q  <= (!write_q && !err_q) ? mem_q[idx_q] : '0;
                            end
                        end else begin
                            // Completion edge: commit an error-free write lane by lane
                            if (write_q && !err_q) begin
                                for (int b = 0; b < STRB_WIDTH; b++) begin
                                    if (strb_q[b]) begin
                                        mem_q[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
                                    end
                                end
                            end
                            pready_q  <= 1'b0;
                            pslverr_q <= 1'b0;
                            prdata_q  <= '0;
                            state_q   <= ST_IDLE;
                        end
                    end else begin
                        // Master abandoned the access: drop the response, no write
                        abort_q   <= 1'b1;
                        pready_q  <= 1'b0;
                        pslverr_q <= 1'b0;
                        prdata_q  <= '0;
                        cnt_q     <= 4'd0;
                        state_q   <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase

            // A setup phase starts a transfer from IDLE or right after an abort
            if (setup_c) begin
                idx_q     <= idx_c;
                write_q   <= PWRITE;
                wdata_q   <= PWDATA;
                strb_q    <= PSTRB;
                err_q     <= err_c;
                cnt_q     <= wait_cfg;
                pready_q  <= (wait_cfg == 4'd0);
                pslverr_q <= (wait_cfg == 4'd0) && err_c;
                prdata_q  <= (!PWRITE && !err_c && (wait_cfg == 4'd0)) ? mem_q[idx_c] : '0;
                state_q   <= ST_ACCESS;
            end
        end
    end

    assign PREADY  = pready_q;
    assign PRDATA  = prdata_q;
    assign PSLVERR = pslverr_q;
    assign abort_o = abort_q;

endmodule

// File: tb/tb_apb3_ms_slave_mem.sv
// Directed testbench for apb3_ms_slave_mem (DATA_WIDTH=32, DEPTH=16, BASE_ADDR=0).
module tb_apb3_ms_slave_mem;

    logic        PCLK;
    logic        PRESETn;
    logic        PSELx;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [3:0]  PSTRB;
    logic [3:0]  wait_cfg;
    logic        PREADY;
    logic [31:0] PRDATA;
    logic        PSLVERR;
    logic        abort_o;

    int total;
    int bad;

    apb3_ms_slave_mem #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (32),
        .STRB_WIDTH (4),
        .DEPTH      (16),
        .BASE_ADDR  (32'h0)
    ) dut (
        .PCLK     (PCLK),
        .PRESETn  (PRESETn),
        .PSELx    (PSELx),
        .PENABLE  (PENABLE),
        .PWRITE   (PWRITE),
        .PADDR    (PADDR),
        .PWDATA   (PWDATA),
        .PSTRB    (PSTRB),
        .wait_cfg (wait_cfg),
        .PREADY   (PREADY),
        .PRDATA   (PRDATA),
        .PSLVERR  (PSLVERR),
        .abort_o  (abort_o)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    // One APB transfer; leaves PSELx high so a following call runs back-to-back.
    // n returns the access cycle (1-based) in which PREADY was first seen high.
    task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic [3:0] ws,
                            output logic [31:0] rdata, output logic err, output int n);
        @(posedge PCLK); #1;
        PSELx = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr;
        PWDATA = data; PSTRB = strb; wait_cfg = ws;
        @(posedge PCLK); #1;
        PENABLE  = 1'b1;
        wait_cfg = 4'hF;  // ignored once the setup edge has passed
        n = 1;
        while (!PREADY && n < 40) begin
            @(posedge PCLK); #1;
            n++;
        end
        rdata = PRDATA;
        err   = PSLVERR;
        if (!PREADY) begin
            total++; bad++;
            $display("FAIL timeout addr=%h: PREADY never rose within %0d cycles", addr, n);
        end
    endtask

    task automatic bus_idle();
        @(posedge PCLK); #1;
        PSELx = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PSTRB = 4'h0;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input logic [3:0] ws, output logic err, output int n);
        logic [31:0] rd;
        apb_xfer(1'b1, addr, data, strb, ws, rd, err, n);
        total++;
        if (rd !== 32'h0) begin
            bad++; $display("FAIL write_prdata addr=%h: got %h want 0", addr, rd);
        end
        bus_idle();
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [3:0] ws,
                           output logic [31:0] rd, output logic err, output int n);
        apb_xfer(1'b0, addr, 32'h0, 4'h0, ws, rd, err, n);
        bus_idle();
    endtask

    task automatic test_reset();
        PRESETn = 1'b0; PSELx = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0; PSTRB = '0; wait_cfg = '0;
        repeat (3) @(posedge PCLK);
        #1;
        total++;
        if ({PREADY, PSLVERR, abort_o, PRDATA} !== 35'h0) begin
            bad++; $display("FAIL reset_outputs: got rdy=%b err=%b abort=%b rdata=%h want all 0",
                            PREADY, PSLVERR, abort_o, PRDATA);
        end
        PRESETn = 1'b1;
        @(posedge PCLK); #1;
    endtask

    task automatic test_basic();
        logic [31:0] rd; logic err; int n;
        do_write(32'h8, 32'hDEADBEEF, 4'hF, 4'd0, err, n);
        total++;
        if (n !== 1 || err !== 1'b0) begin
            bad++; $display("FAIL basic_write: got n=%0d err=%b want n=1 err=0", n, err);
        end
        do_read(32'h8, 4'd0, rd, err, n);
        total++;
        if (rd !== 32'hDEADBEEF || n !== 1 || err !== 1'b0) begin
            bad++; $display("FAIL basic_read: got rd=%h n=%0d err=%b want DEADBEEF 1 0", rd, n, err);
        end
    endtask

    task automatic test_strobe();
        logic [31:0] rd; logic err; int n;
        do_write(32'h4, 32'h11223344, 4'hF, 4'd0, err, n);
        do_write(32'h4, 32'hAABBCCDD, 4'h5, 4'd0, err, n);
        do_read(32'h4, 4'd0, rd, err, n);
        total++;
        if (rd !== 32'h11BB33DD) begin
            bad++; $display("FAIL strobe_merge: got %h want 11BB33DD", rd);
        end
    endtask

    task automatic test_wait();
        logic [31:0] rd; logic err; int n;
        do_read(32'h8, 4'd3, rd, err, n);
        total++;
        if (n !== 4 || rd !== 32'hDEADBEEF || err !== 1'b0) begin
            bad++; $display("FAIL wait3_read: got n=%0d rd=%h err=%b want 4 DEADBEEF 0", n, rd, err);
        end
        do_write(32'h14, 32'h0BADF00D, 4'hF, 4'd2, err, n);
        total++;
        if (n !== 3 || err !== 1'b0) begin
            bad++; $display("FAIL wait2_write: got n=%0d err=%b want 3 0", n, err);
        end
        do_read(32'h14, 4'd1, rd, err, n);
        total++;
        if (n !== 2 || rd !== 32'h0BADF00D) begin
            bad++; $display("FAIL wait1_read: got n=%0d rd=%h want 2 0BADF00D", n, rd);
        end
    endtask

    task automatic test_error();
        logic [31:0] rd; logic err; int n;
        do_write(32'h0, 32'hCAFEF00D, 4'hF, 4'd0, err, n);
        do_write(32'h40, 32'h12345678, 4'hF, 4'd0, err, n);
        total++;
        if (err !== 1'b1 || n !== 1) begin
            bad++; $display("FAIL range_write_err: got err=%b n=%0d want 1 1", err, n);
        end
        do_read(32'h0, 4'd0, rd, err, n);
        total++;
        if (rd !== 32'hCAFEF00D || err !== 1'b0) begin
            bad++; $display("FAIL no_wrap_write: got rd=%h err=%b want CAFEF00D 0", rd, err);
        end
        do_read(32'h6, 4'd0, rd, err, n);
        total++;
        if (err !== 1'b1 || rd !== 32'h0) begin
            bad++; $display("FAIL misaligned_read: got err=%b rd=%h want 1 0", err, rd);
        end
        do_read(32'h3C, 4'd2, rd, err, n);
        total++;
        if (err !== 1'b0 || n !== 3 || rd !== 32'h0) begin
            bad++; $display("FAIL last_word_read: got err=%b n=%0d rd=%h want 0 3 0", err, n, rd);
        end
        do_read(32'h40, 4'd2, rd, err, n);
        total++;
        if (err !== 1'b1 || n !== 3 || rd !== 32'h0) begin
            bad++; $display("FAIL range_read_wait: got err=%b n=%0d rd=%h want 1 3 0", err, n, rd);
        end
    endtask

    task automatic test_abort();
        logic [31:0] rd; logic err; int n;
        do_write(32'hC, 32'h5A5A5A5A, 4'hF, 4'd0, err, n);
        @(posedge PCLK); #1;
        PSELx = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'hC;
        PWDATA = 32'hFFFFFFFF; PSTRB = 4'hF; wait_cfg = 4'd5;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(posedge PCLK); #1;
        PSELx = 1'b0; PENABLE = 1'b0;
        total++;
        if (abort_o !== 1'b0 || PREADY !== 1'b0) begin
            bad++; $display("FAIL abort_early: got abort=%b rdy=%b want 0 0", abort_o, PREADY);
        end
        @(posedge PCLK); #1;
        total++;
        if (abort_o !== 1'b1 || PREADY !== 1'b0 || PSLVERR !== 1'b0) begin
            bad++; $display("FAIL abort_pulse: got abort=%b rdy=%b err=%b want 1 0 0", abort_o, PREADY, PSLVERR);
        end
        @(posedge PCLK); #1;
        total++;
        if (abort_o !== 1'b0 || PREADY !== 1'b0) begin
            bad++; $display("FAIL abort_one_cycle: got abort=%b rdy=%b want 0 0", abort_o, PREADY);
        end
        do_read(32'hC, 4'd0, rd, err, n);
        total++;
        if (rd !== 32'h5A5A5A5A) begin
            bad++; $display("FAIL abort_no_write: got %h want 5A5A5A5A", rd);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic err; int n;
        apb_xfer(1'b1, 32'h20, 32'h01020304, 4'hF, 4'd0, rd, err, n);
        apb_xfer(1'b1, 32'h24, 32'hA0B0C0D0, 4'hF, 4'd1, rd, err, n);
        total++;
        if (n !== 2 || err !== 1'b0) begin
            bad++; $display("FAIL b2b_write: got n=%0d err=%b want 2 0", n, err);
        end
        apb_xfer(1'b0, 32'h20, 32'h0, 4'h0, 4'd0, rd, err, n);
        total++;
        if (rd !== 32'h01020304 || n !== 1) begin
            bad++; $display("FAIL b2b_read0: got rd=%h n=%0d want 01020304 1", rd, n);
        end
        apb_xfer(1'b0, 32'h24, 32'h0, 4'h0, 4'd0, rd, err, n);
        total++;
        if (rd !== 32'hA0B0C0D0 || n !== 1) begin
            bad++; $display("FAIL b2b_read1: got rd=%h n=%0d want A0B0C0D0 1", rd, n);
        end
        bus_idle();
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic err; int n;
        do_write(32'h10, 32'h77777777, 4'hF, 4'd0, err, n);
        @(posedge PCLK); #1;
        PSELx = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h10;
        PWDATA = 32'h99999999; PSTRB = 4'hF; wait_cfg = 4'd4;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(posedge PCLK); #1;
        PRESETn = 1'b0;
        #1;
        total++;
        if ({PREADY, PSLVERR, abort_o, PRDATA} !== 35'h0) begin
            bad++; $display("FAIL reset_mid_outputs: got rdy=%b err=%b abort=%b rdata=%h want all 0",
                            PREADY, PSLVERR, abort_o, PRDATA);
        end
        PSELx = 1'b0; PENABLE = 1'b0;
        @(posedge PCLK); #1;
        PRESETn = 1'b1;
        for (int w = 0; w < 16; w++) begin
            do_read(32'(w * 4), 4'd0, rd, err, n);
            total++;
            if (rd !== 32'h0 || err !== 1'b0) begin
                bad++; $display("FAIL reset_clear word %0d: got rd=%h err=%b want 0 0", w, rd, err);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_basic();
        test_strobe();
        test_wait();
        test_error();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
